// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift_ctrl block: direction state encoding,
// selector levels, and the period-select width.
package shift_ctrl_pkg;

  // Width of the period-select switch bus.
  localparam int NB_SW = 2;

  // Selector levels as seen by the downstream shift register.
  localparam logic SEL_UP   = 1'b0;  // shift toward MSB
  localparam logic SEL_DOWN = 1'b1;  // shift toward LSB

  // Direction FSM states. The encoding doubles as the selector level, so
  // the registered state drives o_selector with no extra logic.
  typedef enum logic {
    ST_UP   = SEL_UP,
    ST_DOWN = SEL_DOWN
  } dir_state_e;

  // Next direction state in ping-pong mode. Only the end in the current
  // travel direction is examined; an all-zero pattern holds the state.
  function automatic dir_state_e pingpong_next(input dir_state_e cur,
                                               input logic msb_lit,
                                               input logic lsb_lit);
    dir_state_e nxt;
    nxt = cur;
    case (cur)
      ST_UP:   if (msb_lit) nxt = ST_DOWN;
      ST_DOWN: if (lsb_lit) nxt = ST_UP;
      default: nxt = ST_UP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/shift_ctrl_tick_gen.sv
// Programmable-rate tick generator. A free-running counter wraps at the
// limit selected by i_sw and emits a one-clock registered strobe on each
// wrap. The limit is re-sampled every cycle, and the wrap test uses '>='
// so a shrinking period never lets the counter run away.
module shift_ctrl_tick_gen
  import shift_ctrl_pkg::*;
#(
  parameter int          NB_COUNT = 32,
  parameter int unsigned LIMIT_0  = 2**20,
  parameter int unsigned LIMIT_1  = 2**22,
  parameter int unsigned LIMIT_2  = 2**24,
  parameter int unsigned LIMIT_3  = 2**26
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic [NB_SW-1:0] i_sw,
  output logic             o_tick
);

  // Terminal counts (limit - 1) for each period selection.
  localparam logic [NB_COUNT-1:0] LAST_0 = NB_COUNT'(LIMIT_0 - 1);
  localparam logic [NB_COUNT-1:0] LAST_1 = NB_COUNT'(LIMIT_1 - 1);
  localparam logic [NB_COUNT-1:0] LAST_2 = NB_COUNT'(LIMIT_2 - 1);
  localparam logic [NB_COUNT-1:0] LAST_3 = NB_COUNT'(LIMIT_3 - 1);

  logic [NB_COUNT-1:0] count_q, count_d;
  logic [NB_COUNT-1:0] last;
  logic                tick_q,  tick_d;

  // Select the terminal count for the currently requested period.
  always_comb begin
    last = LAST_0;
    case (i_sw)
      2'd0:    last = LAST_0;
      2'd1:    last = LAST_1;
      2'd2:    last = LAST_2;
      default: last = LAST_3;
    endcase
  end

  // Advance or wrap the counter; a wrap produces the strobe. Stopped
  // counting holds the count and suppresses strobes.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (i_run) begin
      if (count_q >= last) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + NB_COUNT'(1);
      end
    end
  end

  // Counter and strobe registers, cleared asynchronously.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/shift_ctrl.sv
// Control stage feeding a shift register: produces the enable strobe and
// the shift direction. The direction either follows a switch (fixed mode)
// or bounces between the register ends (ping-pong mode), using the
// register contents fed back on i_shift.
//
// Interface: there is no valid/ready handshake here. o_enable is a
// one-clock strobe that the shift register consumes unconditionally on the
// same edge; o_selector is a level that is stable for at least one cycle
// before each strobe whenever every period is two clocks or longer.
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int          NB_SHIFT = 4,
  parameter int          NB_COUNT = 32,
  parameter int unsigned LIMIT_0  = 2**20,
  parameter int unsigned LIMIT_1  = 2**22,
  parameter int unsigned LIMIT_2  = 2**24,
  parameter int unsigned LIMIT_3  = 2**26
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic [NB_SW-1:0]    i_sw,
  input  logic                i_mode,
  input  logic                i_dir,
  input  logic [NB_SHIFT-1:0] i_shift,
  output logic                o_enable,
  output logic                o_selector
);

  dir_state_e state_q;

  shift_ctrl_tick_gen #(
    .NB_COUNT (NB_COUNT),
    .LIMIT_0  (LIMIT_0),
    .LIMIT_1  (LIMIT_1),
    .LIMIT_2  (LIMIT_2),
    .LIMIT_3  (LIMIT_3)
  ) u_tick_gen (
    .clock   (clock),
    .i_reset (i_reset),
    .i_run   (i_run),
    .i_sw    (i_sw),
    .o_tick  (o_enable)
  );

  // Direction FSM, evaluated every cycle regardless of the strobe so the
  // selector has settled before the next shift. Switching into ping-pong
  // mode continues from whatever state fixed mode left behind.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_UP;
    end else if (!i_mode) begin
      state_q <= i_dir ? ST_DOWN : ST_UP;
    end else begin
      state_q <= pingpong_next(state_q, i_shift[NB_SHIFT-1], i_shift[0]);
    end
  end

  // The state encoding is the selector level.
  assign o_selector = state_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl with short periods (4/8/16/32 clocks).
// A cycle model of the block pushes the expected enable/selector pair into
// a queue before each edge; the pair is popped and compared just after the
// edge. Directed checks on pulse spacing and the ping-pong sequence sit on
// top of the per-cycle scoreboard.
module tb_shift_ctrl;

  localparam int NB_SHIFT = 4;
  localparam int NB_COUNT = 32;

  logic                clock;
  logic                i_reset;
  logic                i_run;
  logic [1:0]          i_sw;
  logic                i_mode;
  logic                i_dir;
  logic [NB_SHIFT-1:0] i_shift;
  logic                o_enable;
  logic                o_selector;

  shift_ctrl #(
    .NB_SHIFT (NB_SHIFT),
    .NB_COUNT (NB_COUNT),
    .LIMIT_0  (4),
    .LIMIT_1  (8),
    .LIMIT_2  (16),
    .LIMIT_3  (32)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_run      (i_run),
    .i_sw       (i_sw),
    .i_mode     (i_mode),
    .i_dir      (i_dir),
    .i_shift    (i_shift),
    .o_enable   (o_enable),
    .o_selector (o_selector)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];
  int          pulse_cyc[$];
  int unsigned lim_tab[4] = '{4, 8, 16, 32};
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  // model of the block
  int unsigned m_cnt = 0;
  logic        m_en  = 1'b0;
  logic        m_sel = 1'b0;

  // behavioural shift register downstream of the DUT
  logic [NB_SHIFT-1:0] sreg     = '0;
  bit                  use_sreg = 1'b0;

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: predict, push, clock, pop, compare.
  task automatic cycle();
    int unsigned lim;
    int unsigned n_cnt;
    logic        n_en;
    logic        n_sel;
    logic [1:0]  e;
    lim = lim_tab[i_sw];
    if (!i_reset) begin
      n_cnt = 0; n_en = 1'b0; n_sel = 1'b0;
    end else begin
      if (i_run) begin
        if (m_cnt >= lim - 1) begin n_cnt = 0;         n_en = 1'b1; end
        else                  begin n_cnt = m_cnt + 1; n_en = 1'b0; end
      end else begin
        n_cnt = m_cnt; n_en = 1'b0;
      end
      if (!i_mode)     n_sel = i_dir;
      else if (!m_sel) n_sel = i_shift[NB_SHIFT-1] ? 1'b1 : 1'b0;
      else             n_sel = i_shift[0] ? 1'b0 : 1'b1;
    end
    exp_q.push_back({n_en, n_sel});
    @(posedge clock);
    // downstream register reacts to the strobe/direction present before the edge
    if (m_en) begin
      if (!m_sel) sreg = sreg << 1;
      else        sreg = sreg >> 1;
    end
    m_cnt = n_cnt; m_en = n_en; m_sel = n_sel;
    cyc++;
    #1;
    if (use_sreg) i_shift = sreg;
    if (exp_q.size() == 0) begin
      chk("scoreboard empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      assert ({o_enable, o_selector} === e) else begin
        n_err++;
        $error("FAIL cycle %0d en/sel: got %b expected %b", cyc, {o_enable, o_selector}, e);
      end
    end
    if (o_enable === 1'b1) pulse_cyc.push_back(cyc);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Pulse count and spacing since 'base' (counter assumed at 0 at base).
  task automatic check_pulses(input string tag, input int n, input int per, input int base);
    chk({tag, " count"}, pulse_cyc.size(), n);
    for (int i = 0; i < pulse_cyc.size(); i++)
      chk({tag, " spacing"}, pulse_cyc[i] - ((i == 0) ? base : pulse_cyc[i-1]), per);
  endtask

  // Advance until the model counter reaches 'target', bounded.
  task automatic run_to_count(input string tag, input int unsigned target);
    for (int k = 0; k < 64 && m_cnt != target; k++) cycle();
    chk(tag, int'(m_cnt), int'(target));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int seq[$];
    int exp_seq[8] = '{1, 2, 4, 8, 4, 2, 1, 2};
    logic [NB_SHIFT-1:0] prev;
    int c8, cs;
    logic [1:0] dir_pat[5] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00};

    i_reset = 1'b1; i_run = 1'b0; i_sw = 2'd0;
    i_mode  = 1'b0; i_dir = 1'b0; i_shift = '0;

    // 1. reset, then idle with the counter stopped
    #2 i_reset = 1'b0;
    #1 chk("reset enable", int'(o_enable), 0);
    chk("reset selector", int'(o_selector), 0);
    run_cycles(2);
    i_reset = 1'b1;
    pulse_cyc.delete();
    run_cycles(20);
    chk("idle no pulses", pulse_cyc.size(), 0);

    // 2. period 4, then period 32, ten pulses each
    i_run = 1'b1; i_sw = 2'd0;
    pulse_cyc.delete(); base = cyc;
    run_cycles(40);
    check_pulses("period4", 10, 4, base);
    i_sw = 2'd3;
    pulse_cyc.delete(); base = cyc;
    run_cycles(320);
    check_pulses("period32", 10, 32, base);

    // 3. pause the counter at 2 for 20 cycles, then resume
    i_sw = 2'd0;
    run_to_count("pause reach", 2);
    i_run = 1'b0;
    pulse_cyc.delete();
    run_cycles(20);
    chk("paused no pulses", pulse_cyc.size(), 0);
    i_run = 1'b1;
    cycle();
    chk("resume edge1", int'(o_enable), 0);
    cycle();
    chk("resume edge2", int'(o_enable), 1);

    // 4. shrink period while counter is past the new terminal count
    i_sw = 2'd3;
    run_to_count("shrink reach", 20);
    i_sw = 2'd0;
    cycle();
    chk("shrink immediate", int'(o_enable), 1);
    pulse_cyc.delete(); base = cyc;
    run_cycles(8);
    check_pulses("after shrink", 2, 4, base);

    // 5. ping-pong with the downstream register seeded to 0001
    sreg = 4'b0001; i_shift = sreg; use_sreg = 1'b1; i_mode = 1'b1;
    seq.push_back(int'(sreg));
    c8 = -1; cs = -1;
    for (int i = 0; i < 40; i++) begin
      prev = sreg;
      cycle();
      if (sreg != prev) seq.push_back(int'(sreg));
      if (sreg == 4'b1000 && c8 < 0) c8 = cyc;
      if (o_selector === 1'b1 && cs < 0) cs = cyc;
    end
    chk("pingpong length", (seq.size() >= 8) ? 8 : seq.size(), 8);
    for (int i = 0; i < 8 && i < seq.size(); i++)
      chk($sformatf("pingpong step%0d", i), seq[i], exp_seq[i]);
    chk("reverse latency", cs - c8, 1);

    // 6. fixed mode follows i_dir one cycle later, MSB lit is ignored
    use_sreg = 1'b0; i_mode = 1'b0; i_shift = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      i_dir = dir_pat[i][0];
      cycle();
      chk($sformatf("fixed dir%0d", i), int'(o_selector), int'(dir_pat[i][0]));
    end

    // async reset while a strobe is high
    i_dir = 1'b1;
    for (int k = 0; k < 64 && m_en != 1'b1; k++) cycle();
    chk("strobe before reset", int'(o_enable), 1);
    #2 i_reset = 1'b0;
    #1 chk("async rst enable", int'(o_enable), 0);
    chk("async rst selector", int'(o_selector), 0);
    m_cnt = 0; m_en = 1'b0; m_sel = 1'b0;
    cycle();
    i_reset = 1'b1;
    pulse_cyc.delete(); base = cyc;
    run_cycles(8);
    check_pulses("after reset", 2, 4, base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
